// File: rtl/conv_mac_stream.sv
// Streaming convolution MAC: accumulates T operand products per output pixel,
// applies optional ReLU and saturation, and emits pixels in row-major order.
module conv_mac_stream #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int FILTER_SIZE   = 3,
    parameter int OFMAP_SIZE    = 4,
    parameter int NUM_CH        = 1,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 relu_en,
    input  logic signed [2*IP_DATA_WIDTH-1:0]    bias,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [IP_DATA_WIDTH-1:0]      in_act,
    input  logic signed [IP_DATA_WIDTH-1:0]      in_wgt,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [2*IP_DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(OFMAP_SIZE)-1:0]        out_row,
    output logic [$clog2(OFMAP_SIZE)-1:0]        out_col,
    output logic                                 busy,
    output logic                                 done
);
    localparam int OW = 2 * IP_DATA_WIDTH;
    localparam int T  = FILTER_SIZE * FILTER_SIZE * NUM_CH;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam int RW = $clog2(OFMAP_SIZE);

    localparam logic [CW-1:0] LAST_TERM = CW'(T - 1);
    localparam logic [RW-1:0] LAST_POS  = RW'(OFMAP_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OW+1){1'b1}}, {(OW-1){1'b0}}};

    if (ACC_WIDTH < 2*IP_DATA_WIDTH + $clog2(T+1)) begin : g_acc_width_check
        $error("conv_mac_stream: ACC_WIDTH too small for the term count");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, OUT, DONE} state_t;

    state_t                        state, state_next;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [CW-1:0]                 term_cnt;
    logic [RW-1:0]                 row, col;
    logic signed [OW-1:0]          bias_q;
    logic                          relu_q;
    logic signed [OW-1:0]          product;
    logic signed [ACC_WIDTH-1:0]   sum, relu_val;
    logic signed [OW-1:0]          sat_val;
    logic                          last_term, last_pix;

    // Handshake semantics: a transfer happens on a rising edge where valid and
    // ready are both high; ready never depends combinationally on valid.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_row   = row;
    assign out_col   = col;

    assign last_term = (term_cnt == LAST_TERM);
    assign last_pix  = (row == LAST_POS) && (col == LAST_POS);
    assign product   = in_act * in_wgt;
    assign sum       = acc + {{(ACC_WIDTH-OW){product[OW-1]}}, product};
    assign relu_val  = (relu_q && sum[ACC_WIDTH-1]) ? '0 : sum;

    always_comb begin
        sat_val = relu_val[OW-1:0];
        if (relu_val > SAT_MAX) begin
            sat_val = SAT_MAX[OW-1:0];
        end else if (relu_val < SAT_MIN) begin
            sat_val = SAT_MIN[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (in_valid && last_term) state_next = OUT;
            OUT:     if (out_ready) state_next = last_pix ? DONE : ACCUM;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            term_cnt <= '0;
            row      <= '0;
            col      <= '0;
            out_data <= '0;
            bias_q   <= '0;
            relu_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= {{(ACC_WIDTH-OW){bias[OW-1]}}, bias};
                        bias_q   <= bias;
                        relu_q   <= relu_en;
                        term_cnt <= '0;
                        row      <= '0;
                        col      <= '0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc      <= sum;
                        term_cnt <= term_cnt + 1'b1;
                        if (last_term) begin
                            out_data <= sat_val;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (col == LAST_POS) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        // Bias is reloaded from the latched copy so mid-map
                        // changes on the bias port cannot leak in.
                        if (!last_pix) begin
                            acc      <= {{(ACC_WIDTH-OW){bias_q[OW-1]}}, bias_q};
                            term_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed bench for conv_mac_stream: per-map pixel model feeding an expected
// queue, one compare process on output handshakes, plus literal and timing checks.
module tb_conv_mac_stream;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int RW = 2;
    localparam int T  = 9;
    localparam int N  = 4;

    logic                 clk = 1'b0;
    logic                 rst, start, relu_en, in_valid, out_ready;
    logic                 in_ready, out_valid, busy, done;
    logic signed [OW-1:0] bias, out_data;
    logic signed [IW-1:0] in_act, in_wgt;
    logic [RW-1:0]        out_row, out_col;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [OW+2*RW-1:0] exp_q[$];

    always #5 clk = ~clk;

    conv_mac_stream dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_act(input int mode, input int a, input int k);
        return (mode == 0) ? a : k - 4;
    endfunction

    function automatic int op_wgt(input int mode, input int w, input int k);
        return (mode == 0) ? w : k + 1;
    endfunction

    // Pixel value from first principles: bias plus dot product, ReLU, clamp.
    function automatic logic signed [OW-1:0] model_pix(input int b, input bit relu,
                                                       input int mode, input int a, input int w);
        int s;
        s = b;
        for (int k = 0; k < T; k++) s += op_act(mode, a, k) * op_wgt(mode, w, k);
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return OW'(s);
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    always @(negedge clk) begin : compare
        logic [OW+2*RW-1:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=%0d required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("pix_data", int'(out_data), int'($signed(e[OW+2*RW-1:2*RW])));
                chk("pix_row", int'(out_row), int'(e[2*RW-1:RW]));
                chk("pix_col", int'(out_col), int'(e[RW-1:0]));
            end
        end
    end

    task automatic feed_terms(input int n, input int mode, input int a, input int w,
                              input bit gaps, input bit stray);
        int cnt;
        int guard;
        bit hs;
        cnt = 0;
        guard = 0;
        while (cnt < n && guard < 200) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_act   = IW'(op_act(mode, a, cnt));
            in_wgt   = IW'(op_wgt(mode, w, cnt));
            start    = stray && (cnt == 0);
            @(negedge clk);
            hs = in_valid && in_ready;
            step();
            if (hs) cnt++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (guard >= 200) chk("feed_timeout", cnt, n);
    endtask

    task automatic run_map(input int b, input bit relu, input int mode, input int a,
                           input int w, input bit gaps, input int bp_pix, input int lit);
        logic signed [OW-1:0] d0;
        logic [RW-1:0] r0, c0;
        int dc0;
        dc0 = done_cnt;
        for (int p = 0; p < N*N; p++)
            exp_q.push_back({model_pix(b, relu, mode, a, w), RW'(p / N), RW'(p % N)});
        bias = OW'(b);
        relu_en = relu;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("accum_in_ready", in_ready, 1);
        step();
        for (int p = 0; p < N*N; p++) begin
            feed_terms(T, mode, a, w, gaps, p == 1);
            @(negedge clk);
            chk("latency_out_valid", out_valid, 1);
            chk("out_in_ready", in_ready, 0);
            if (p == 0) chk("first_pixel_literal", int'(out_data), lit);
            if (p == bp_pix) begin
                d0 = out_data;
                r0 = out_row;
                c0 = out_col;
                for (int i = 0; i < 5; i++) begin
                    step();
                    start = (i == 1);
                    if (i == 1) begin
                        bias = ~bias;
                        relu_en = ~relu_en;
                    end
                    @(negedge clk);
                    chk("bp_data_stable", int'(out_data), int'(d0));
                    chk("bp_row_stable", int'(out_row), int'(r0));
                    chk("bp_col_stable", int'(out_col), int'(c0));
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                end
                start = 1'b0;
            end
            step();
            out_ready = 1'b1;
            @(negedge clk);
            step();
            out_ready = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_done_busy", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - dc0, 1);
        step();
    endtask

    task automatic reset_mid_map();
        bias = 0;
        relu_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        feed_terms(4, 0, 1, 1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_out_col", int'(out_col), 0);
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("post_rst_no_output", out_valid, 0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        relu_en = 1'b0;
        bias = '0;
        in_valid = 1'b0;
        in_act = '0;
        in_wgt = '0;
        out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_out_data", int'(out_data), 0);
        rst = 1'b0;
        step();

        run_map(0, 1'b0, 0, 1, 1, 1'b0, -1, 9);
        run_map(0, 1'b0, 0, -2, 3, 1'b0, -1, -54);
        run_map(0, 1'b1, 0, -2, 3, 1'b0, -1, 0);
        run_map(100, 1'b0, 0, 1, 1, 1'b0, -1, 109);
        run_map(0, 1'b0, 0, 127, 127, 1'b0, -1, 32767);
        run_map(0, 1'b0, 0, -128, 127, 1'b0, -1, -32768);
        run_map(0, 1'b0, 0, 1, 1, 1'b0, 5, 9);
        run_map(-10, 1'b0, 1, 0, 0, 1'b1, -1, 50);
        run_map(0, 1'b0, 0, 1, 1, 1'b1, -1, 9);
        reset_mid_map();
        run_map(0, 1'b0, 0, 1, 1, 1'b0, -1, 9);

        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_mac_stream.md
CONV_MAC_STREAM -- requirements
Module: conv_mac_stream

Parameters
REQ-001 The block SHALL have parameter IP_DATA_WIDTH, default 8, the signed operand width (in_act, in_wgt).
REQ-002 The block SHALL have parameter FILTER_SIZE, default 3, the kernel edge length.
REQ-003 The block SHALL have parameter OFMAP_SIZE, default 4, the output feature-map edge length.
REQ-004 The block SHALL have parameter NUM_CH, default 1, the input channels summed per output pixel.
REQ-005 The block SHALL have parameter ACC_WIDTH, default 32, the signed accumulator width, and SHALL fail elaboration if ACC_WIDTH < 2*IP_DATA_WIDTH+$clog2(T+1), where T = FILTER_SIZE*FILTER_SIZE*NUM_CH.

Interface
REQ-006 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port start, input, 1 bit: begins one feature-map computation; it SHALL be honoured only in IDLE.
REQ-009 Port relu_en, input, 1 bit: ReLU mode, latched on start.
REQ-010 Port bias, input, 2*IP_DATA_WIDTH bits, signed: per-map bias, latched on start.
REQ-011 Port in_valid, input, 1 bit, and port in_ready, output, 1 bit: operand handshake.
REQ-012 Port in_act, input, IP_DATA_WIDTH bits, signed: activation operand.
REQ-013 Port in_wgt, input, IP_DATA_WIDTH bits, signed: weight operand.
REQ-014 Port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-015 Port out_data, output, 2*IP_DATA_WIDTH bits, signed: saturated pixel result.
REQ-016 Ports out_row and out_col, outputs, $clog2(OFMAP_SIZE) bits each: coordinates of out_data.
REQ-017 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 Port done, output, 1 bit: one-cycle pulse when the map completes.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM, OUT and DONE.
REQ-020 IDLE: in_ready=0 and out_valid=0; on start the block SHALL load acc with sign-extended bias, clear term_cnt, row and col, latch relu_en, and go to ACCUM.
REQ-021 ACCUM: in_ready=1; each in_valid&&in_ready cycle SHALL add the full-precision signed product in_act*in_wgt (sign-extended to ACC_WIDTH) to acc and increment term_cnt; cycles without in_valid SHALL leave all state unchanged.
REQ-022 On the handshake with term_cnt==T-1, the block SHALL register out_data = sat(relu(acc+product)) and go to OUT, so out_valid asserts on the next cycle (latency 1).
REQ-023 relu: if the latched relu_en is set, a negative value SHALL become 0; sat: clamp to [-2^(2*IP_DATA_WIDTH-1), 2^(2*IP_DATA_WIDTH-1)-1].
REQ-024 OUT: out_valid=1 and in_ready=0; out_data, out_row and out_col SHALL hold stable until out_valid&&out_ready.
REQ-025 On the OUT handshake: col increments; at OFMAP_SIZE-1, col wraps to 0 and row increments.
REQ-026 On the OUT handshake at the last pixel (row=col=OFMAP_SIZE-1), the block SHALL go to DONE; otherwise acc is reloaded with the latched bias, term_cnt is cleared, and the block returns to ACCUM.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; start asserted in DONE SHALL be ignored.
REQ-028 start asserted in ACCUM or OUT SHALL be ignored; changes on bias and relu_en mid-map SHALL have no effect.
REQ-029 in_ready SHALL be a registered/state-decoded output with no combinational path from in_valid or out_ready.

Reset
REQ-030 With rst high at a clock edge, the block SHALL go to IDLE and clear acc, term_cnt, row, col, out_data, out_valid, in_ready, busy and done to 0, including mid-ACCUM and mid-OUT; no partial result SHALL be emitted afterwards.

Verification (defaults, T=9)
REQ-031 Unit operands: start with bias=0, relu_en=0, in_act=1, in_wgt=1 continuously -> 16 results of 9 in row-major order (0,0)..(3,3), each out_valid one cycle after the 9th input; done pulses once after the 16th output handshake.
REQ-032 Negative operands: in_act=-2, in_wgt=3 -> out_data=-54 with relu_en=0, and 0 with relu_en=1; bias=100 with unit operands -> 109.
REQ-033 Saturation: in_act=127, in_wgt=127 -> 32767 (true sum 145161); in_act=-128, in_wgt=127 -> -32768 (true sum -146304).
REQ-034 Backpressure and gaps: out_ready held low for 5 cycles -> out_data, out_row and out_col stable and in_ready=0 throughout; random in_valid gaps in ACCUM -> results identical to the gap-free run.
REQ-035 Reset and stray start: rst after 4 accepted terms -> all outputs 0 next cycle; a new start with unit operands -> first result 9 at (0,0); a start pulse in OUT -> no effect on the sequence.
